lcd_pattern_gen: RTL and testbench

Self-contained RGB LCD timing and test-pattern generator for the dclk domain. It replaces the fixed walking-bit colour bar with parametrised panel timing, channel widths and bar count, plus a run-time selectable set of patterns. Mode and solid colour change only on frame boundaries, and a scrolling mode animates once per frame. It sits between the video PLL output and the panel pins.

---
 rtl/lcd_pattern_gen.sv | 167 ++++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_gen.sv
// RGB LCD timing generator with run-time selectable test patterns.
// Mode, solid colour and the scroll offset change only on frame boundaries.
module lcd_pattern_gen #(
    parameter int H_ACTIVE    = 480,
    parameter int H_FP        = 8,
    parameter int H_SYNC      = 4,
    parameter int H_BP        = 43,
    parameter int V_ACTIVE    = 272,
    parameter int V_FP        = 8,
    parameter int V_SYNC      = 4,
    parameter int V_BP        = 12,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int R_W         = 5,
    parameter int G_W         = 6,
    parameter int B_W         = 5,
    parameter int NUM_BARS    = 16,
    parameter int CHECK_LOG2  = 4,
    parameter int SCROLL_STEP = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               mode,
    input  logic [R_W+G_W+B_W-1:0]   solid_rgb,
    output logic                     hs,
    output logic                     vs,
    output logic                     de,
    output logic [R_W-1:0]           lcd_r,
    output logic [G_W-1:0]           lcd_g,
    output logic [B_W-1:0]           lcd_b,
    output logic [9:0]               active_x,
    output logic [9:0]               active_y,
    output logic                     frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int RGB_W   = R_W + G_W + B_W;
    // Counters are at least 10 bits so the grey ramp and active_x/y slices always exist.
    localparam int HW      = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
    localparam int VW      = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;
    localparam int BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int CBAR_W  = H_ACTIVE / 8;

    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_BP_S   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_BP_S   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [RGB_W-1:0] TOP_BIT = RGB_W'(1) << (RGB_W - 1);
    localparam logic [RGB_W-1:0] WHITE   = {RGB_W{1'b1}};

    logic [HW-1:0]    h_cnt;
    logic [VW-1:0]    v_cnt;
    logic [2:0]       mode_q;
    logic [RGB_W-1:0] solid_q;
    logic [9:0]       frame_cnt;
    logic [HW-1:0]    offset;
    logic             h_last;
    logic             frame_end;
    logic             de_next;
    logic             hs_next;
    logic             vs_next;
    logic [RGB_W-1:0] pix_next;
    logic [RGB_W-1:0] rgb_q;
    logic [HW:0]      off_sum;
    logic [HW:0]      x_sum;
    logic [HW-1:0]    x_eff;
    logic [HW-1:0]    walk_idx;
    logic [7:0]       g8;

    // Eight classic bars; with bar index b the channels are r=~b[1], g=~b[2], b=~b[0].
    function automatic logic [RGB_W-1:0] classic_bar(input logic [HW-1:0] x);
        logic [HW-1:0] b;
        b = x / HW'(CBAR_W);
        if (b > HW'(7)) b = HW'(7);
        return {{R_W{~b[1]}}, {G_W{~b[2]}}, {B_W{~b[0]}}};
    endfunction

    assign h_last    = (h_cnt == H_LAST);
    assign frame_end = h_last && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    assign off_sum = {1'b0, offset} + (HW+1)'(SCROLL_STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= '0;
            solid_q   <= '0;
            frame_cnt <= '0;
            offset    <= '0;
        end else if (frame_end) begin
            mode_q    <= mode;
            solid_q   <= solid_rgb;
            frame_cnt <= frame_cnt + 10'd1;
            offset    <= (off_sum >= {1'b0, H_ACT_C}) ? HW'(off_sum - {1'b0, H_ACT_C})
                                                      : off_sum[HW-1:0];
        end
    end

    assign de_next = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_next = ((h_cnt >= H_SYNC_S) && (h_cnt < H_BP_S)) ? HS_POL : ~HS_POL;
    assign vs_next = ((v_cnt >= V_SYNC_S) && (v_cnt < V_BP_S)) ? VS_POL : ~VS_POL;

    // x and offset are both below H_ACTIVE, so one conditional subtract wraps the sum.
    assign x_sum = {1'b0, h_cnt} + {1'b0, offset};
    assign x_eff = (x_sum >= {1'b0, H_ACT_C}) ? HW'(x_sum - {1'b0, H_ACT_C}) : x_sum[HW-1:0];
    assign g8    = h_cnt[7:0];

    always_comb begin
        walk_idx = h_cnt / HW'(BAR_W);
        if (walk_idx > HW'(NUM_BARS - 1)) walk_idx = HW'(NUM_BARS - 1);
    end

    always_comb begin
        pix_next = '0;
        if (de_next) begin
            case (mode_q)
                3'd0: pix_next = TOP_BIT >> walk_idx;
                3'd1: pix_next = classic_bar(h_cnt);
                3'd2: pix_next = {g8[7 -: R_W], g8[7 -: G_W], g8[7 -: B_W]};
                3'd3: pix_next = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? WHITE : '0;
                3'd4: pix_next = solid_q;
                3'd5: pix_next = classic_bar(x_eff);
                default: pix_next = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            rgb_q       <= '0;
            active_x    <= '0;
            active_y    <= '0;
            frame_start <= 1'b0;
        end else begin
            hs          <= hs_next;
            vs          <= vs_next;
            de          <= de_next;
            rgb_q       <= pix_next;
            active_x    <= de_next ? h_cnt[9:0] : 10'd0;
            active_y    <= de_next ? v_cnt[9:0] : 10'd0;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign lcd_r = rgb_q[RGB_W-1 -: R_W];
    assign lcd_g = rgb_q[G_W+B_W-1 -: G_W];
    assign lcd_b = rgb_q[B_W-1:0];

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Bench for lcd_pattern_gen on a reduced 76x26 raster (64x20 active) so many frames fit in a short run.
// Pixel vectors and input changes come from tables keyed by frame and raster position.
module tb_lcd_pattern_gen;
    localparam int HA = 64, HFP = 4, HSY = 2, HBP = 6, HT = HA + HFP + HSY + HBP;
    localparam int VA = 20, VFP = 2, VSY = 2, VBP = 2, VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
    localparam int NF = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  mode = 3'd0;
    logic [15:0] solid_rgb = 16'h0;
    logic        hs, vs, de, frame_start;
    logic [4:0]  lcd_r;
    logic [5:0]  lcd_g;
    logic [4:0]  lcd_b;
    logic [9:0]  active_x, active_y;
    logic [15:0] rgb;

    assign rgb = {lcd_r, lcd_g, lcd_b};

    lcd_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .R_W(5), .G_W(6), .B_W(5),
        .NUM_BARS(16), .CHECK_LOG2(4), .SCROLL_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
        .hs(hs), .vs(vs), .de(de), .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
        .active_x(active_x), .active_y(active_y), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { int frame; int x; int y; logic [15:0] exp; } vec_t;
    typedef struct { int frame; int cyc; logic [2:0] mode; logic [15:0] solid; } sched_t;
    vec_t   vecs[$];
    sched_t sched[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    initial begin
        int x, y, geom_err, de_cyc, hs_low, vs_low, de_rises, hs_first, vs_first, de_fall, de_rise2;
        logic prev_de, e_de, e_hs, e_vs, e_fs;

        // Frames 0..1: walking bit, mid-frame switch to solid, last-cycle capture vs one cycle late.
        vecs.push_back('{0, 0, 0, 16'h8000});  vecs.push_back('{0, 3, 0, 16'h8000});
        vecs.push_back('{0, 4, 0, 16'h4000});  vecs.push_back('{0, 63, 0, 16'h0001});
        vecs.push_back('{0, 60, 5, 16'h0001}); vecs.push_back('{0, 32, 7, 16'h0080});
        vecs.push_back('{0, 0, 15, 16'h8000}); vecs.push_back('{0, 5, 15, 16'h4000});
        vecs.push_back('{0, 63, 19, 16'h0001});
        vecs.push_back('{1, 0, 0, 16'hF800});  vecs.push_back('{1, 10, 12, 16'hF800});
        vecs.push_back('{1, 63, 19, 16'hF800});
        vecs.push_back('{2, 0, 0, 16'h001F});  vecs.push_back('{2, 63, 19, 16'h001F});
        // Frame 3 checker, frame 4 grey ramp, frame 5 classic bars.
        vecs.push_back('{3, 15, 0, 16'h0000}); vecs.push_back('{3, 16, 0, 16'hFFFF});
        vecs.push_back('{3, 16, 16, 16'h0000}); vecs.push_back('{3, 0, 16, 16'hFFFF});
        vecs.push_back('{3, 33, 17, 16'hFFFF}); vecs.push_back('{3, 31, 15, 16'hFFFF});
        vecs.push_back('{4, 0, 0, 16'h0000});  vecs.push_back('{4, 37, 3, 16'h2124});
        vecs.push_back('{4, 63, 9, 16'h39E7});
        vecs.push_back('{5, 0, 0, 16'hFFFF});  vecs.push_back('{5, 7, 0, 16'hFFFF});
        vecs.push_back('{5, 8, 0, 16'hFFE0});  vecs.push_back('{5, 16, 0, 16'h07FF});
        vecs.push_back('{5, 24, 0, 16'h07E0}); vecs.push_back('{5, 32, 0, 16'hF81F});
        vecs.push_back('{5, 40, 0, 16'hF800}); vecs.push_back('{5, 48, 0, 16'h001F});
        vecs.push_back('{5, 63, 0, 16'h0000}); vecs.push_back('{5, 47, 1, 16'hF800});
        // Scroll: offset = 4*frame mod 64.
        vecs.push_back('{6, 0, 0, 16'h07E0});  vecs.push_back('{6, 39, 0, 16'h0000});
        vecs.push_back('{6, 40, 0, 16'hFFFF}); vecs.push_back('{6, 63, 0, 16'h07FF});
        vecs.push_back('{7, 35, 0, 16'h0000}); vecs.push_back('{7, 36, 0, 16'hFFFF});
        vecs.push_back('{16, 0, 0, 16'hFFFF}); vecs.push_back('{16, 63, 0, 16'h0000});
        vecs.push_back('{16, 8, 0, 16'hFFE0});
        vecs.push_back('{17, 3, 0, 16'hFFFF}); vecs.push_back('{17, 4, 0, 16'hFFE0});
        vecs.push_back('{17, 60, 0, 16'hFFFF}); vecs.push_back('{17, 59, 0, 16'h0000});

        sched.push_back('{0, 10 * HT, 3'd4, 16'hF800});
        sched.push_back('{1, 5 * HT, 3'd2, 16'h07E0});
        sched.push_back('{1, FRAME - 2, 3'd4, 16'h001F});
        sched.push_back('{1, FRAME - 1, 3'd3, 16'h001F});
        sched.push_back('{2, HT, 3'd3, 16'h0000});
        sched.push_back('{3, HT, 3'd2, 16'h0000});
        sched.push_back('{4, HT, 3'd1, 16'h0000});
        sched.push_back('{5, HT, 3'd5, 16'h0000});
        sched.push_back('{17, HT, 3'd3, 16'h0000});

        repeat (5) @(negedge clk);
        check("reset de", 32'(de), 32'd0);
        check("reset rgb", 32'(rgb), 32'd0);
        check("reset hs", 32'(hs), 32'd1);
        check("reset vs", 32'(vs), 32'd1);
        check("reset frame_start", 32'(frame_start), 32'd0);
        check("reset active_xy", 32'({active_x, active_y}), 32'd0);
        rst_n = 1'b1;

        for (int f = 0; f < NF; f++) begin
            geom_err = 0; de_cyc = 0; hs_low = 0; vs_low = 0; de_rises = 0;
            hs_first = -1; vs_first = -1; de_fall = -1; de_rise2 = -1; prev_de = 1'b0;
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                x = c % HT;
                y = c / HT;
                e_de = (x < HA) && (y < VA);
                e_hs = !((x >= HA + HFP) && (x < HA + HFP + HSY));
                e_vs = !((y >= VA + VFP) && (y < VA + VFP + VSY));
                e_fs = (c == 0);
                if (de !== e_de || hs !== e_hs || vs !== e_vs || frame_start !== e_fs) geom_err++;
                if (active_x !== (e_de ? 10'(x) : 10'd0) || active_y !== (e_de ? 10'(y) : 10'd0)) geom_err++;
                if (!e_de && rgb !== 16'h0) geom_err++;
                if (de === 1'b1) de_cyc++;
                if (hs === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = c; end
                if (vs === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = c; end
                if (de === 1'b1 && !prev_de) begin
                    de_rises++;
                    if (de_rises == 2) de_rise2 = c;
                end
                if (de === 1'b0 && prev_de && de_fall < 0) de_fall = c;
                prev_de = (de === 1'b1);
                foreach (vecs[i])
                    if (vecs[i].frame == f && vecs[i].x == x && vecs[i].y == y)
                        check($sformatf("rgb f%0d (%0d,%0d)", f, x, y), 32'(rgb), 32'(vecs[i].exp));
                foreach (sched[j])
                    if (sched[j].frame == f && sched[j].cyc == c) begin
                        mode = sched[j].mode;
                        solid_rgb = sched[j].solid;
                    end
            end
            check($sformatf("geometry mismatches f%0d", f), 32'(geom_err), 32'd0);
            check($sformatf("de cycles f%0d", f), 32'(de_cyc), 32'(HA * VA));
            check($sformatf("de lines f%0d", f), 32'(de_rises), 32'(VA));
            check($sformatf("hs low cycles f%0d", f), 32'(hs_low), 32'(HSY * VT));
            check($sformatf("vs low cycles f%0d", f), 32'(vs_low), 32'(VSY * HT));
            if (f == 0) begin
                check("first de fall", 32'(de_fall), 32'(HA));
                check("second de rise (line period)", 32'(de_rise2), 32'(HT));
                check("first hs low after de rise", 32'(hs_first), 32'(HA + HFP));
                check("first vs low", 32'(vs_first), 32'((VA + VFP) * HT));
            end
        end

        // Frame 18 runs the checker; reset it in the middle of line 10.
        @(negedge clk);
        check("f18 frame_start", 32'(frame_start), 32'd1);
        check("f18 checker (0,0)", 32'(rgb), 32'h0000);
        repeat (10 * HT + 30) @(negedge clk);
        check("f18 checker (30,10)", 32'(rgb), 32'hFFFF);
        check("f18 de before reset", 32'(de), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset de", 32'(de), 32'd0);
        check("mid reset rgb", 32'(rgb), 32'd0);
        check("mid reset hs/vs", 32'({hs, vs}), 32'd3);
        check("mid reset active_xy", 32'({active_x, active_y}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset frame_start", 32'(frame_start), 32'd1);
        check("post reset de", 32'(de), 32'd1);
        check("post reset active_xy", 32'({active_x, active_y}), 32'd0);
        check("post reset mode0 (0,0)", 32'(rgb), 32'h8000);
        repeat (16) @(negedge clk);
        check("post reset mode0 (16,0)", 32'(rgb), 32'h0800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
